if_id_ctrl: RTL and testbench
=============================

# if_id_ctrl

IF/ID pipeline register and front-end control for the 16-bit, 8-bit-PC MIPS-style pipeline. It consumes the fetch stage's `pc`/`instr` outputs and drives its `instr_fetch_enable`, `imm_branch_offset`, `branch_enable` and `jump` inputs. It owns load-use stalls, jump redirects from ID, taken-branch redirects from EX, and squashing of wrong-path instructions. Because the fetch branch adder is relative to the *current* fetch PC, the block converts EX branch targets into fetch-relative deltas, using several hops when the delta exceeds the 6-bit range.

## Interface
Parameters:
- `JMP_OPCODE`, default 4'hD: opcode field value decoded as jump in ID.
- `LD_OPCODE`, default 4'h8: load opcode; informational, EX supplies `ex_mem_read`.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-low reset.
- `pc` input 8: current fetch PC from the fetch stage.
- `instr` input 16: instruction at `pc`. Fields: opcode [15:12], rs [11:9], rt [8:6], imm6 [5:0].
- `ex_pc` input 8: PC of the instruction in EX.
- `ex_branch_taken` input 1: the EX instruction is a taken branch.
- `ex_branch_offset` input 6: signed offset of the EX branch. Target = `ex_pc` + 1 + sext(offset).
- `ex_mem_read` input 1: the EX instruction is a load.
- `ex_rd` input 3: destination register of the EX instruction.
- `instr_fetch_enable` output 1: PC update enable to the fetch stage.
- `imm_branch_offset` output 6: offset, or absolute jump target, to the fetch stage.
- `branch_enable` output 1: fetch next PC = `pc` + 1 + sext(`imm_branch_offset`).
- `jump` output 1: fetch next PC = sext(`imm_branch_offset`).
- `id_pc` output 8: registered PC in ID.
- `id_instr` output 16: registered instruction in ID. Value 16'h0000 is a NOP.
- `id_valid` output 1: ID holds a real instruction.

## Operation
- States: RUN and HOP.
- **IF/ID register update, RUN state:**
  - Normal: latch `pc`/`instr` and set `id_valid`=1.
  - Squash: `id_instr`=0, `id_valid`=0; `id_pc` still latches `pc`.
  - Stall: hold all three outputs.
- **Priority in RUN (highest first):**
  1. **EX taken branch.**
     - Compute `tgt` = `ex_pc`+1+sext(off), mod 256.
     - Compute `delta` = `tgt` − (`pc`+1), mod 256.
     - If `delta` ∈ [−32,31]: `branch_enable`=1, `imm_branch_offset`=`delta`[5:0], squash IF/ID.
     - Otherwise: emit +31 if `delta`[7]=0, else −32; store `tgt`, go to HOP, squash.
     - The ID jump and any stall condition are ignored.
  2. **ID jump** (`id_valid` and opcode==`JMP_OPCODE`): `jump`=1, `imm_branch_offset`=`id_instr`[5:0], squash IF/ID.
  3. **Load-use stall** (`id_valid`, `ex_mem_read`, `ex_rd`≠0, `ex_rd` equals rs or rt, opcode≠`JMP_OPCODE`): `instr_fetch_enable`=0, hold IF/ID.
     - The bubble toward EX is implied: ID/EX sees `id_valid` gated off.
     - Exactly one stall cycle per hazard; the next cycle proceeds normally.
  4. **Otherwise:** `instr_fetch_enable`=1, `branch_enable`=0, `jump`=0, `imm_branch_offset`=0.
- **HOP state:**
  - Each cycle: recompute `delta` = stored `tgt` − (`pc`+1), emit a clamped hop, squash IF/ID.
  - When the delta fits, issue the final hop and return to RUN.
  - At most 8 hops.
  - `ex_branch_taken` is ignored in HOP (EX holds a bubble).
- `branch_enable` and `jump` are never asserted together. `instr_fetch_enable`=1 whenever either is asserted.

## Timing
- Fetch-control outputs are combinational from state, IF/ID registers and current inputs. They take effect on the PC at the next edge.
- IF/ID outputs are registered.
- Redirect penalties:
  - Taken branch: 2 bubbles (ID and IF squashed), plus 1 per extra hop.
  - Jump: 1 bubble.
  - Load-use: 1 bubble.
- Reset (`rst`=0 at an edge): state=RUN, `id_pc`=0, `id_instr`=0, `id_valid`=0.
  - While `rst`=0: `instr_fetch_enable`=1, `branch_enable`=0, `jump`=0, `imm_branch_offset`=0.
  - Reset during HOP abandons the hop; the stored target is cleared.
- PC arithmetic is 8-bit wrap-around: 8'hFF+1 → 8'h00.

## Configuration
- `IFID_LONG_BRANCH_EN` defined: multi-hop HOP state as above.
- Undefined: no HOP state. An out-of-range `delta` is truncated to `delta`[5:0] and issued in a single cycle. The resulting PC is architecturally wrong; the ISA must keep branch targets within fetch-relative reach. Penalty is always 2 bubbles.

## Test plan
- **Sequential fetch:** `pc` 0x10..0x14, no hazards → `id_pc` follows one cycle later, `id_valid`=1, `instr_fetch_enable`=1 throughout.
- **Load-use:** EX `ex_mem_read`=1, `ex_rd`=3; ID instr rs=3 → exactly one cycle with `instr_fetch_enable`=0 and IF/ID held; next cycle advances.
- **Jump:** ID instr 16'hD_005 (imm6=0x05) → `jump`=1, `imm_branch_offset`=0x05; next `id_valid`=0; then `id_pc`=0x05.
- **Near branch:** `ex_pc`=0x20, off=+4, `pc`=0x22 → `branch_enable`=1, offset 0x02 (tgt 0x25); two bubbles, then `id_pc`=0x25.
- **Far branch, `IFID_LONG_BRANCH_EN`:** `ex_pc`=0x00, off=+31, `pc`=0xC0 with wrap → hops issued until PC=0x20 (tgt), `id_valid`=0 during every hop cycle. Also apply reset mid-hop → RUN, `id_valid`=0.
- **Priority:** `ex_branch_taken` with a jump in ID and a load-use condition in the same cycle → only `branch_enable`=1; no stall, no jump.

Source files
------------

// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register and front-end redirect/stall control for the 8-bit-PC pipeline.
// Optional multi-hop long-branch support is enabled by defining IFID_LONG_BRANCH_EN.
module if_id_ctrl #(
  parameter logic [3:0] JMP_OPCODE = 4'hD,
  parameter logic [3:0] LD_OPCODE  = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pc,
  input  logic [15:0] instr,
  input  logic [7:0]  ex_pc,
  input  logic        ex_branch_taken,
  input  logic [5:0]  ex_branch_offset,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rd,
  output logic        instr_fetch_enable,
  output logic [5:0]  imm_branch_offset,
  output logic        branch_enable,
  output logic        jump,
  output logic [7:0]  id_pc,
  output logic [15:0] id_instr,
  output logic        id_valid
);

`ifdef IFID_LONG_BRANCH_EN
  typedef enum logic {RUN = 1'b0, HOP = 1'b1} state_e;
  state_e     state_q, state_d;
  logic [7:0] tgt_q, tgt_d;
`endif

  logic [7:0]  id_pc_q;
  logic [15:0] id_instr_q;
  logic        id_valid_q;
  logic        stalled_q, stalled_d;
  logic        hop_active_s, squash_s, stall_s, jump_hit_s, load_use_s;
  logic [7:0]  ex_tgt_s, base_tgt_s, delta_s;

  // A delta fits the 6-bit signed fetch offset when bits [7:5] are a pure sign extension.
  function automatic logic fits6(input logic [7:0] d);
    return (d[7:5] == 3'b000) || (d[7:5] == 3'b111);
  endfunction

  assign ex_tgt_s = ex_pc + 8'd1 + {{2{ex_branch_offset[5]}}, ex_branch_offset};

`ifdef IFID_LONG_BRANCH_EN
  assign hop_active_s = (state_q == HOP);
  assign base_tgt_s   = hop_active_s ? tgt_q : ex_tgt_s;
`else
  assign hop_active_s = 1'b0;
  assign base_tgt_s   = ex_tgt_s;
`endif

  assign delta_s = base_tgt_s - (pc + 8'd1);

  // A jump opcode that aliases the load opcode would be a broken configuration; never decode it as a jump.
  assign jump_hit_s = id_valid_q && (id_instr_q[15:12] == JMP_OPCODE) && (JMP_OPCODE != LD_OPCODE);
  assign load_use_s = id_valid_q && ex_mem_read && (ex_rd != 3'd0) &&
                      ((ex_rd == id_instr_q[11:9]) || (ex_rd == id_instr_q[8:6])) &&
                      (id_instr_q[15:12] != JMP_OPCODE);

  // Fetch-control decode: redirect priority, hop sequencing and load-use stall.
  always_comb begin
    instr_fetch_enable = 1'b1;
    branch_enable      = 1'b0;
    jump               = 1'b0;
    imm_branch_offset  = 6'd0;
    squash_s           = 1'b0;
    stall_s            = 1'b0;
    stalled_d          = 1'b0;
`ifdef IFID_LONG_BRANCH_EN
    state_d            = state_q;
    tgt_d              = tgt_q;
`endif
    if (!rst) begin
      stall_s = 1'b0;
    end else if (hop_active_s || ex_branch_taken) begin
      branch_enable = 1'b1;
      squash_s      = 1'b1;
      if (fits6(delta_s)) begin
        imm_branch_offset = delta_s[5:0];
`ifdef IFID_LONG_BRANCH_EN
        state_d           = RUN;
`endif
      end else begin
`ifdef IFID_LONG_BRANCH_EN
        imm_branch_offset = delta_s[7] ? 6'h20 : 6'h1F;
        state_d           = HOP;
        tgt_d             = base_tgt_s;
`else
        imm_branch_offset = delta_s[5:0];
`endif
      end
    end else if (jump_hit_s) begin
      jump              = 1'b1;
      imm_branch_offset = id_instr_q[5:0];
      squash_s          = 1'b1;
    end else if (load_use_s && !stalled_q) begin
      // stalled_q bounds each hazard to one bubble even if EX is slow to clear.
      instr_fetch_enable = 1'b0;
      stall_s            = 1'b1;
      stalled_d          = 1'b1;
    end else begin
      stalled_d = 1'b0;
    end
  end

  // IF/ID pipeline register with stall hold and squash.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_pc_q    <= 8'd0;
      id_instr_q <= 16'h0000;
      id_valid_q <= 1'b0;
      stalled_q  <= 1'b0;
    end else if (stall_s) begin
      id_pc_q    <= id_pc_q;
      id_instr_q <= id_instr_q;
      id_valid_q <= id_valid_q;
      stalled_q  <= stalled_d;
    end else if (squash_s) begin
      id_pc_q    <= pc;
      id_instr_q <= 16'h0000;
      id_valid_q <= 1'b0;
      stalled_q  <= stalled_d;
    end else begin
      id_pc_q    <= pc;
      id_instr_q <= instr;
      id_valid_q <= 1'b1;
      stalled_q  <= stalled_d;
    end
  end

`ifdef IFID_LONG_BRANCH_EN
  // Hop state and stored far-branch target; reset abandons any hop in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      tgt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end
`endif

  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_valid = id_valid_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Self-checking bench for if_id_ctrl: directed scenarios then random traffic, with a closed-loop
// fetch model and a behavioural reference of the redirect/stall rules. Honours IFID_LONG_BRANCH_EN.
module tb_if_id_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [7:0]  ex_pc;
  logic        ex_branch_taken;
  logic [5:0]  ex_branch_offset;
  logic        ex_mem_read;
  logic [2:0]  ex_rd;
  logic        instr_fetch_enable;
  logic [5:0]  imm_branch_offset;
  logic        branch_enable;
  logic        jump;
  logic [7:0]  id_pc;
  logic [15:0] id_instr;
  logic        id_valid;

  always #5 clk = ~clk;

  if_id_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .ex_pc(ex_pc), .ex_branch_taken(ex_branch_taken), .ex_branch_offset(ex_branch_offset),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .instr_fetch_enable(instr_fetch_enable), .imm_branch_offset(imm_branch_offset),
    .branch_enable(branch_enable), .jump(jump),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid)
  );

  int n_pass = 0;
  int n_total = 0;

  // stimulus
  bit          rst_v;
  logic [7:0]  pc_v;
  logic [15:0] instr_v;
  logic [7:0]  exp_v;
  bit          bt_v;
  logic [5:0]  off_v;
  bit          mr_v;
  logic [2:0]  rd_v;
  logic [15:0] imem [256];

  // reference model state
  logic [7:0]  m_id_pc;
  logic [15:0] m_id_instr;
  bit          m_id_valid;
  bit          m_stalled;
  bit          m_hop;
  int          m_tgt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int sext6(input logic [5:0] v);
    return (v > 6'd31) ? int'(v) - 64 : int'(v);
  endfunction

  function automatic int mod256(input int x);
    return ((x % 256) + 256) % 256;
  endfunction

  // signed distance from the next sequential PC to the target, in [-128,127]
  function automatic int wrap_delta(input int tgt, input int p);
    int d;
    d = mod256(tgt - p - 1);
    if (d > 127) d = d - 256;
    return d;
  endfunction

  task automatic step();
    int d, tgt, e_off, act;
    bit e_fe, e_be, e_j, lu;
    logic [5:0] off6;
    logic [31:0] off_bits;
    rst = rst_v; pc = pc_v; instr = instr_v; ex_pc = exp_v;
    ex_branch_taken = bt_v; ex_branch_offset = off_v; ex_mem_read = mr_v; ex_rd = rd_v;
    #2;
    e_fe = 1'b1; e_be = 1'b0; e_j = 1'b0; e_off = 0; act = 0;
    lu = m_id_valid && mr_v && (rd_v != 3'd0) && (m_id_instr[15:12] != 4'hD) &&
         ((rd_v == m_id_instr[11:9]) || (rd_v == m_id_instr[8:6]));
    if (!rst_v) begin
      act = 3;
    end else if (m_hop) begin
      d = wrap_delta(m_tgt, int'(pc_v));
      e_be = 1'b1; act = 1;
      if (d >= -32 && d <= 31) begin
        e_off = d; m_hop = 1'b0;
      end else begin
        e_off = (d > 0) ? 31 : -32;
      end
    end else if (bt_v) begin
      tgt = mod256(int'(exp_v) + 1 + sext6(off_v));
      d = wrap_delta(tgt, int'(pc_v));
      e_be = 1'b1; act = 1;
      if (d >= -32 && d <= 31) begin
        e_off = d;
      end else begin
`ifdef IFID_LONG_BRANCH_EN
        e_off = (d > 0) ? 31 : -32; m_hop = 1'b1; m_tgt = tgt;
`else
        e_off = d;
`endif
      end
    end else if (m_id_valid && m_id_instr[15:12] == 4'hD) begin
      e_j = 1'b1; e_off = sext6(m_id_instr[5:0]); act = 1;
    end else if (lu && !m_stalled) begin
      e_fe = 1'b0; act = 2;
    end
    off_bits = e_off;
    off6 = off_bits[5:0];
    chk("fetch_enable", {15'd0, instr_fetch_enable}, {15'd0, e_fe});
    chk("branch_enable", {15'd0, branch_enable}, {15'd0, e_be});
    chk("jump", {15'd0, jump}, {15'd0, e_j});
    chk("imm_branch_offset", {10'd0, imm_branch_offset}, {10'd0, off6});
    m_stalled = (act == 2);
    if (act == 3) begin m_hop = 1'b0; m_tgt = 0; end
    @(posedge clk);
    case (act)
      3: begin m_id_pc = 8'd0; m_id_instr = 16'h0000; m_id_valid = 1'b0; end
      2: begin end
      1: begin m_id_pc = pc_v; m_id_instr = 16'h0000; m_id_valid = 1'b0; end
      default: begin m_id_pc = pc_v; m_id_instr = instr_v; m_id_valid = 1'b1; end
    endcase
    #1;
    chk("id_pc", {8'd0, id_pc}, {8'd0, m_id_pc});
    chk("id_instr", id_instr, m_id_instr);
    chk("id_valid", {15'd0, id_valid}, {15'd0, m_id_valid});
    // fetch stage model
    if (!e_fe) pc_v = pc_v;
    else if (e_be) pc_v = 8'(int'(pc_v) + 1 + sext6(off6));
    else if (e_j) pc_v = 8'(sext6(off6));
    else pc_v = pc_v + 8'd1;
  endtask

  initial begin
    logic [15:0] w;
    m_id_pc = 8'd0; m_id_instr = 16'h0000; m_id_valid = 1'b0;
    m_stalled = 1'b0; m_hop = 1'b0; m_tgt = 0;
    rst_v = 1'b0; pc_v = 8'd0; instr_v = 16'h0000; exp_v = 8'd0;
    bt_v = 1'b0; off_v = 6'd0; mr_v = 1'b0; rd_v = 3'd0;
    #1;
    step(); step();

    // sequential fetch 0x10..0x14
    rst_v = 1'b1; pc_v = 8'h10;
    for (int i = 0; i < 5; i++) begin
      instr_v = {4'h1, 12'(i)};
      step();
    end
    chk("seq_last_pc", {8'd0, id_pc}, 16'h0014);

    // load-use: ex_rd=3 against an ID instruction with rs=3
    mr_v = 1'b1; rd_v = 3'd3; instr_v = 16'h1600;
    step();
    step();
    chk("lu_held_instr", id_instr, 16'h1600);
    step();
    mr_v = 1'b0; rd_v = 3'd0;

    // jump 0xD005
    instr_v = 16'hD005; step();
    instr_v = 16'h1001; step();
    chk("jump_squash_valid", {15'd0, id_valid}, 16'h0000);
    step();
    chk("jump_landing_pc", {8'd0, id_pc}, 16'h0005);

    // near branch: ex_pc=0x20, off=+4, pc=0x22
    pc_v = 8'h22; exp_v = 8'h20; off_v = 6'd4; bt_v = 1'b1;
    step();
    bt_v = 1'b0;
    step();
    chk("near_landing_pc", {8'd0, id_pc}, 16'h0025);

    // priority: branch beats jump in ID and load-use
    instr_v = 16'hDA05; mr_v = 1'b1; rd_v = 3'd5; step();
    exp_v = 8'h30; off_v = 6'd2; bt_v = 1'b1; step();
    bt_v = 1'b0; mr_v = 1'b0; rd_v = 3'd0; instr_v = 16'h1000;
    step();

    // far branch: ex_pc=0x00, off=+31, pc=0xC0
    pc_v = 8'hC0; exp_v = 8'h00; off_v = 6'd31; bt_v = 1'b1;
    step();
    bt_v = 1'b0;
    for (int k = 0; k < 10 && m_hop; k++) step();
    step();
`ifdef IFID_LONG_BRANCH_EN
    chk("far_landing_pc", {8'd0, id_pc}, 16'h0020);
`endif

    // reset in the middle of a far branch
    pc_v = 8'hC0; bt_v = 1'b1; step();
    bt_v = 1'b0; step();
    rst_v = 1'b0; step();
    chk("midhop_reset_valid", {15'd0, id_valid}, 16'h0000);
    rst_v = 1'b1; step(); step();

    // randomized traffic with closed-loop fetch
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) w[15:12] = 4'hD;
      imem[i] = w;
    end
    for (int n = 0; n < 400; n++) begin
      rst_v = ($urandom_range(0, 60) != 0);
      bt_v  = ($urandom_range(0, 5) == 0);
      exp_v = 8'($urandom);
      off_v = 6'($urandom);
      mr_v  = ($urandom_range(0, 1) == 1);
      rd_v  = 3'($urandom);
      instr_v = imem[pc_v];
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
